lsu_initiator: RTL and testbench

- Load/store initiator between the execute stage and the byte-addressed data RAM.
- Turns one decoded L-type or S-type instruction into one or two word-aligned requests on a req/ack memory port. The second request is used only for a misaligned access that crosses a word boundary.
- Drives byte enables and lane-shifted write data for stores.
- For loads, reassembles the returned bytes and applies LB/LH/LW/LBU/LHU extension before returning a 32-bit result to writeback.

---
 rtl/lsu_initiator_if.sv | 13 +
 rtl/lsu_initiator.sv | 144 ++++++++++++++
 tb/tb_lsu_initiator.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_initiator_if.sv
`timescale 1ns/1ps
// lsu_initiator_if: word-aligned request/acknowledge port between the initiator and the data RAM
interface lsu_initiator_if #(parameter int ADDR_W = 32);
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [3:0] be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic ack;
  modport master(output req, we, addr, be, wdata, input rdata, ack);
  modport slave(input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/lsu_initiator.sv
`timescale 1ns/1ps
// lsu_initiator: splits one load/store into one or two word-aligned beats and extends load results
module lsu_initiator #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W = 32,
  parameter logic [4:0] LTYPE = 5'd1,
  parameter logic [4:0] STYPE = 5'd2
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic [4:0] itype_i,
  input  logic [2:0] funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0] wdata_i,
  lsu_initiator_if.master mem,
  output logic [31:0] load_data_o,
  output logic done_o,
  output logic busy_o,
  output logic fault_o
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0] be_q, be_d, be1_q, be1_d;
  logic [31:0] wd_q, wd_d, wd1_q, wd1_d, rbuf0_q, rbuf0_d, load_q, load_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0] off_q, off_d;
  logic [2:0] f3_q, f3_d;
  logic we_q, we_d, split_q, split_d, fault_q, fault_d;
  logic is_ld, is_st, legal, tmo;
  logic [3:0] szm;
  logic [7:0] mask;
  logic [63:0] sdata, word2;
  logic [31:0] raw, ext;
  assign is_ld = itype_i == LTYPE;
  assign is_st = itype_i == STYPE;
  assign legal = is_ld ? !(funct3_i[1:0] == 2'd3 || funct3_i[2:1] == 2'b11) : is_st && funct3_i < 3'd3;
  assign szm = funct3_i[1] ? 4'hF : funct3_i[0] ? 4'h3 : 4'h1;
  assign mask = {4'b0, szm} << addr_i[1:0];
  assign sdata = {32'b0, wdata_i} << {addr_i[1:0], 3'b000};
  // the beat being acknowledged supplies its word directly, so the result is ready on the FIN entry edge
  assign word2 = {state_q == BEAT1 ? mem.rdata : 32'b0, state_q == BEAT0 ? mem.rdata : rbuf0_q};
  assign raw = 32'(word2 >> {off_q, 3'b000});
  assign ext = f3_q[1] ? raw :
               f3_q[0] ? {{16{~f3_q[2] & raw[15]}}, raw[15:0]} :
                         {{24{~f3_q[2] & raw[7]}}, raw[7:0]};
  assign tmo = (TIMEOUT != 0) && (cnt_q + 32'd1 == 32'(TIMEOUT));
  assign mem.req = state_q == BEAT0 || state_q == BEAT1;
  assign mem.we = we_q;
  assign mem.addr = addr_q;
  assign mem.be = be_q;
  assign mem.wdata = wd_q;
  assign load_data_o = load_q;
  assign done_o = state_q == FIN;
  assign busy_o = state_q != IDLE;
  assign fault_o = state_q == FIN && fault_q;
  // next-state: latch the request, step through beats, abort on timeout
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    be_d = be_q;
    be1_d = be1_q;
    wd_d = wd_q;
    wd1_d = wd1_q;
    rbuf0_d = rbuf0_q;
    load_d = load_q;
    cnt_d = cnt_q;
    off_d = off_q;
    f3_d = f3_q;
    we_d = we_q;
    split_d = split_q;
    fault_d = fault_q;
    if (state_q == IDLE && start_i) begin
      fault_d = !legal;
      cnt_d = '0;
      state_d = legal ? BEAT0 : FIN;
      if (legal) begin
        f3_d = funct3_i;
        off_d = addr_i[1:0];
        we_d = is_st;
        addr_d = {addr_i[ADDR_W-1:2], 2'b00};
        be_d = mask[3:0];
        be1_d = mask[7:4];
        wd_d = is_st ? sdata[31:0] : 32'b0;
        wd1_d = is_st ? sdata[63:32] : 32'b0;
        split_d = |mask[7:4];
      end
    end else if (state_q == BEAT0 || state_q == BEAT1) begin
      if (mem.ack) begin
        cnt_d = '0;
        rbuf0_d = state_q == BEAT0 ? mem.rdata : rbuf0_q;
        if (state_q == BEAT0 && split_q) begin
          state_d = BEAT1;
          addr_d = addr_q + ADDR_W'(4);
          be_d = be1_q;
          wd_d = wd1_q;
        end else begin
          state_d = FIN;
          load_d = we_q ? load_q : ext;
        end
      end else if (tmo) begin
        state_d = FIN;
        fault_d = 1'b1;
        cnt_d = '0;
      end else
        cnt_d = cnt_q + 32'd1;
    end else if (state_q == FIN)
      state_d = IDLE;
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      be_q <= '0;
      be1_q <= '0;
      wd_q <= '0;
      wd1_q <= '0;
      rbuf0_q <= '0;
      load_q <= '0;
      cnt_q <= '0;
      off_q <= '0;
      f3_q <= '0;
      we_q <= 1'b0;
      split_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      be_q <= be_d;
      be1_q <= be1_d;
      wd_q <= wd_d;
      wd1_q <= wd1_d;
      rbuf0_q <= rbuf0_d;
      load_q <= load_d;
      cnt_q <= cnt_d;
      off_q <= off_d;
      f3_q <= f3_d;
      we_q <= we_d;
      split_q <= split_d;
      fault_q <= fault_d;
    end
endmodule

// File: tb/tb_lsu_initiator.sv
`timescale 1ns/1ps
// tb_lsu_initiator: scoreboard bench with a wait-state memory model for the load/store initiator
module tb_lsu_initiator;
  localparam logic [4:0] LT = 5'd1;
  localparam logic [4:0] ST = 5'd2;
  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic [4:0] itype = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] load_data;
  logic done, busy, fault;
  lsu_initiator_if #(.ADDR_W(32)) mif();
  lsu_initiator #(.TIMEOUT(4), .ADDR_W(32), .LTYPE(LT), .STYPE(ST)) dut (
    .clk(clk), .reset(rst_n), .start_i(start), .itype_i(itype), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata), .mem(mif), .load_data_o(load_data),
    .done_o(done), .busy_o(busy), .fault_o(fault)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] a; logic [3:0] be; logic [31:0] wd; logic we;} beat_t;
  typedef struct {logic f; logic [31:0] ld; int lat; int reqc; int rises;} res_t;
  beat_t beat_q[$];
  res_t res_q[$];
  res_t r;
  logic [31:0] ram [logic [31:0]];
  int total = 0, bad = 0, cyc = 0, s0 = 0, reqc = 0, rises = 0, wcnt = 0, dly = 0;
  bit ack_en = 1, got_done = 0, req_prev = 0;
  logic [31:0] last_ld = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input logic we);
    beat_t b;
    b.a = a; b.be = be; b.wd = wd; b.we = we;
    beat_q.push_back(b);
  endtask

  always @(posedge clk) cyc++;

  // memory slave plus beat/result scoreboard, all sampled mid-cycle
  always @(negedge clk) begin
    if (mif.req) begin
      reqc++;
      if (!req_prev) rises++;
    end
    req_prev = mif.req;
    if (mif.req && beat_q.size() > 0) begin
      chk("beat_addr", mif.addr, beat_q[0].a);
      chk("beat_be", mif.be, beat_q[0].be);
      chk("beat_wdata", mif.wdata, beat_q[0].wd);
      chk("beat_we", mif.we, beat_q[0].we);
    end else if (mif.req && ack_en)
      chk("req_unexp", mif.req, 0);
    if (mif.req && ack_en && wcnt == dly) begin
      mif.ack = 1;
      mif.rdata = ram.exists(mif.addr) ? ram[mif.addr] : 32'h0;
      if (beat_q.size() > 0) void'(beat_q.pop_front());
      wcnt = 0;
    end else begin
      mif.ack = 0;
      wcnt = mif.req ? wcnt + 1 : 0;
    end
    if (done) begin
      got_done = 1;
      if (res_q.size() == 0) chk("done_unexp", done, 0);
      else begin
        r = res_q.pop_front();
        chk("fault", fault, r.f);
        chk("load_data", load_data, r.ld);
        chk("latency", cyc - s0, r.lat);
        chk("req_cycles", reqc, r.reqc);
        chk("req_rises", rises, r.rises);
      end
    end else if (fault)
      chk("fault_alone", fault, 0);
  end

  task automatic run_op(input logic [4:0] it, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int d, input logic f, input logic [31:0] ld, input int reqn, input bit poke);
    res_t e;
    e.f = f; e.ld = ld; e.reqc = reqn; e.rises = reqn > 0 ? 1 : 0; e.lat = 1 + reqn;
    res_q.push_back(e);
    dly = d; got_done = 0; reqc = 0; rises = 0;
    itype = it; funct3 = f3; addr = a; wdata = wd; start = 1; s0 = cyc;
    @(negedge clk);
    for (int i = 0; i < 60 && !got_done; i++) begin
      if (poke && i == 2) begin
        chk("busy_wait", busy, 1);
        itype = ST; funct3 = 3'd2; addr = 32'h300; start = 1;
      end else start = 0;
      @(negedge clk);
    end
    start = 0;
    chk("done_seen", got_done, 1);
    chk("beats_left", beat_q.size(), 0);
    if (!f && it == LT) last_ld = ld;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", mif.req, 0);
    chk("rst_we", mif.we, 0);
    chk("rst_addr", mif.addr, 0);
    chk("rst_be", mif.be, 0);
    chk("rst_wdata", mif.wdata, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    rst_n = 1;
    @(negedge clk);
    push_beat(32'h100, 4'hF, 32'hDEADBEEF, 1);
    run_op(ST, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, last_ld, 1, 0);
    ram[32'h200] = 32'h80FF7F01;
    ram[32'h204] = 32'h00000055;
    push_beat(32'h200, 4'h8, 0, 0);
    run_op(LT, 3'd0, 32'h203, 0, 0, 0, 32'hFFFFFF80, 1, 0);
    push_beat(32'h200, 4'h8, 0, 0);
    run_op(LT, 3'd4, 32'h203, 0, 0, 0, 32'h00000080, 1, 0);
    push_beat(32'h200, 4'h2, 0, 0);
    run_op(LT, 3'd0, 32'h201, 0, 0, 0, 32'h0000007F, 1, 0);
    push_beat(32'h200, 4'hC, 0, 0);
    run_op(LT, 3'd5, 32'h202, 0, 0, 0, 32'h000080FF, 1, 0);
    push_beat(32'h200, 4'hC, 0, 0);
    run_op(LT, 3'd1, 32'h202, 0, 1, 0, 32'hFFFF80FF, 2, 0);
    push_beat(32'h200, 4'h8, 0, 0);
    push_beat(32'h204, 4'h1, 0, 0);
    run_op(LT, 3'd1, 32'h203, 0, 0, 0, 32'h00005580, 2, 0);
    ram[32'h1FC] = 32'hAABB0000;
    ram[32'h200] = 32'h0000CCDD;
    push_beat(32'h1FC, 4'hC, 0, 0);
    push_beat(32'h200, 4'h3, 0, 0);
    run_op(LT, 3'd2, 32'h1FE, 0, 0, 0, 32'hCCDDAABB, 2, 0);
    push_beat(32'h4, 4'h8, 32'h34000000, 1);
    push_beat(32'h8, 4'h1, 32'h00000012, 1);
    run_op(ST, 3'd1, 32'h7, 32'h1234, 3, 0, last_ld, 8, 0);
    push_beat(32'h0, 4'h8, 32'hAB000000, 1);
    run_op(ST, 3'd0, 32'h3, 32'h123456AB, 0, 0, last_ld, 1, 0);
    push_beat(32'h0, 4'hC, 32'h33440000, 1);
    push_beat(32'h4, 4'h3, 32'h00001122, 1);
    run_op(ST, 3'd2, 32'h2, 32'h11223344, 0, 0, last_ld, 2, 0);
    push_beat(32'hFFFFFFFC, 4'hE, 32'hB2C3D400, 1);
    push_beat(32'h0, 4'h1, 32'h000000A1, 1);
    run_op(ST, 3'd2, 32'hFFFFFFFD, 32'hA1B2C3D4, 0, 0, last_ld, 2, 0);
    run_op(LT, 3'd3, 32'h10, 0, 0, 1, last_ld, 0, 0);
    run_op(ST, 3'd4, 32'h10, 0, 0, 1, last_ld, 0, 0);
    run_op(5'd7, 3'd0, 32'h10, 0, 0, 1, last_ld, 0, 0);
    push_beat(32'h200, 4'hF, 0, 0);
    run_op(LT, 3'd2, 32'h200, 0, 3, 0, 32'h0000CCDD, 4, 1);
    ack_en = 0;
    run_op(LT, 3'd2, 32'h300, 0, 0, 1, last_ld, 4, 0);
    got_done = 0;
    itype = LT; funct3 = 3'd2; addr = 32'h40; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("mid_req", mif.req, 1);
    chk("mid_busy", busy, 1);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_req", mif.req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ld", load_data, 0);
    rst_n = 1;
    repeat (6) @(negedge clk);
    chk("midrst_no_done", got_done, 0);
    ack_en = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
